// File: rtl/pwm_ramp_ctrl.sv
// Start/ramp/stop sequencer driving the pwm block's period, duty, reset and enable inputs.
// Define PWM_RAMP_SOFT_STOP_EN to ramp duty down to zero on stop instead of cutting it at once.
module pwm_ramp_ctrl #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] period_in,
    input  logic [W-1:0] step,
    input  logic [W-1:0] target_duty,
    input  logic         target_valid,
    output logic         target_ready,
    input  logic         ovf,
    input  logic         fault,
    input  logic         fault_clr,
    output logic [W-1:0] pwm_period,
    output logic [W-1:0] pwm_duty,
    output logic         pwm_reset,
    output logic         pwm_enable,
    output logic         ovf_trigger_enable,
    output logic         busy,
    output logic         at_target,
    output logic         fault_flag
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StRamp = 3'd2;
    localparam logic [2:0] StHold = 3'd3;
    localparam logic [2:0] StStop = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] target_q, target_d;
    logic         pwm_reset_q, pwm_reset_d;
    logic         en_q, en_d;
    logic         ovf_en_q, ovf_en_d;
    logic         fault_flag_q, fault_flag_d;

    logic [W-1:0] step_eff;
    logic [W-1:0] lim;
    logic [W-1:0] tgt_new;
    logic [W-1:0] tgt_eff;
    logic [W-1:0] ramp_next;
    logic         xfer;

    // Move cur toward tgt by at most stp; the extra bit catches carry and borrow.
    function automatic logic [W-1:0] slew(input logic [W-1:0] cur,
                                          input logic [W-1:0] tgt,
                                          input logic [W-1:0] stp);
        logic [W:0] up;
        logic [W:0] dn;
        up = {1'b0, cur} + {1'b0, stp};
        dn = {1'b0, cur} - {1'b0, stp};
        if (cur < tgt) begin
            return (up > {1'b0, tgt}) ? tgt : up[W-1:0];
        end else if (cur > tgt) begin
            return (dn[W] || (dn[W-1:0] < tgt)) ? tgt : dn[W-1:0];
        end else begin
            return cur;
        end
    endfunction

    assign step_eff     = (step == '0) ? {{(W-1){1'b0}}, 1'b1} : step;
    assign target_ready = ~fault_flag_q &
                          ((state_q == StIdle) || (state_q == StRamp) || (state_q == StHold));
    assign xfer         = target_valid & target_ready;
    // Before LOAD the period register is stale, so clamp against the incoming period.
    assign lim          = (state_q == StIdle) ? period_in : period_q;
    assign tgt_new      = (target_duty > lim) ? lim : target_duty;
    assign tgt_eff      = xfer ? tgt_new : target_q;
`ifdef PWM_RAMP_SOFT_STOP_EN
    assign ramp_next    = slew(duty_q, (state_q == StStop) ? '0 : tgt_eff, step_eff);
`else
    assign ramp_next    = slew(duty_q, tgt_eff, step_eff);
`endif

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        duty_d       = duty_q;
        target_d     = target_q;
        pwm_reset_d  = pwm_reset_q;
        en_d         = en_q;
        ovf_en_d     = ovf_en_q;
        fault_flag_d = fault_flag_q;

        if (xfer) begin
            target_d = tgt_new;
        end

        case (state_q)
            StIdle: begin
                pwm_reset_d = 1'b1;
                en_d        = 1'b0;
                ovf_en_d    = 1'b0;
                duty_d      = '0;
                if (start && !fault_flag_q && !fault) begin
                    state_d  = StLoad;
                    period_d = period_in;
                end
            end
            StLoad: begin
                period_d    = period_in;
                target_d    = (target_q > period_in) ? period_in : target_q;
                state_d     = StRamp;
                pwm_reset_d = 1'b0;
                en_d        = 1'b1;
                ovf_en_d    = 1'b1;
            end
            StRamp: begin
                if (stop) begin
                    state_d  = StStop;
`ifdef PWM_RAMP_SOFT_STOP_EN
                    target_d = '0;
`else
                    target_d = target_q;
`endif
                end else if (ovf) begin
                    duty_d = ramp_next;
                    if (ramp_next == tgt_eff) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (stop) begin
                    state_d  = StStop;
`ifdef PWM_RAMP_SOFT_STOP_EN
                    target_d = '0;
`else
                    target_d = target_q;
`endif
                end else if (xfer && (tgt_new != duty_q)) begin
                    state_d = StRamp;
                end
            end
            StStop: begin
`ifdef PWM_RAMP_SOFT_STOP_EN
                target_d = '0;
                if (duty_q == '0) begin
                    state_d     = StIdle;
                    pwm_reset_d = 1'b1;
                    en_d        = 1'b0;
                    ovf_en_d    = 1'b0;
                end else if (ovf) begin
                    duty_d = ramp_next;
                    if (ramp_next == '0) begin
                        state_d     = StIdle;
                        pwm_reset_d = 1'b1;
                        en_d        = 1'b0;
                        ovf_en_d    = 1'b0;
                    end
                end
`else
                duty_d      = '0;
                state_d     = StIdle;
                pwm_reset_d = 1'b1;
                en_d        = 1'b0;
                ovf_en_d    = 1'b0;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fault_clr && !fault) begin
            fault_flag_d = 1'b0;
        end
        if (fault) begin
            fault_flag_d = 1'b1;
            state_d      = StIdle;
            duty_d       = '0;
            pwm_reset_d  = 1'b1;
            en_d         = 1'b0;
            ovf_en_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            period_q     <= '0;
            duty_q       <= '0;
            target_q     <= '0;
            pwm_reset_q  <= 1'b1;
            en_q         <= 1'b0;
            ovf_en_q     <= 1'b0;
            fault_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            target_q     <= target_d;
            pwm_reset_q  <= pwm_reset_d;
            en_q         <= en_d;
            ovf_en_q     <= ovf_en_d;
            fault_flag_q <= fault_flag_d;
        end
    end

    assign pwm_period         = period_q;
    assign pwm_duty           = duty_q;
    assign pwm_reset          = pwm_reset_q;
    // Only combinational output: a fault kills the PWM without waiting for a clock edge.
    assign pwm_enable         = en_q & ~fault;
    assign ovf_trigger_enable = ovf_en_q;
    assign busy               = (state_q != StIdle);
    assign at_target          = (state_q == StHold);
    assign fault_flag         = fault_flag_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed stimulus, expected duty updates checked through a scoreboard.
// Honours PWM_RAMP_SOFT_STOP_EN to select the expected stop sequence.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop;
    logic [31:0] period_in, step, target_duty;
    logic        target_valid, target_ready;
    logic        ovf, fault, fault_clr;
    logic [31:0] pwm_period, pwm_duty;
    logic        pwm_reset, pwm_enable, ovf_trigger_enable;
    logic        busy, at_target, fault_flag;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prev_duty = '0;
    logic        mon_en = 1'b0;

    pwm_ramp_ctrl #(.W(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .stop               (stop),
        .period_in          (period_in),
        .step               (step),
        .target_duty        (target_duty),
        .target_valid       (target_valid),
        .target_ready       (target_ready),
        .ovf                (ovf),
        .fault              (fault),
        .fault_clr          (fault_clr),
        .pwm_period         (pwm_period),
        .pwm_duty           (pwm_duty),
        .pwm_reset          (pwm_reset),
        .pwm_enable         (pwm_enable),
        .ovf_trigger_enable (ovf_trigger_enable),
        .busy               (busy),
        .at_target          (at_target),
        .fault_flag         (fault_flag)
    );

    always #5 clk = ~clk;

    // Every duty change the DUT presents must match the oldest expected value.
    always @(negedge clk) begin
        if (mon_en && (pwm_duty !== prev_duty)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL duty_update: got %0d, required no change (stays %0d)",
                         pwm_duty, prev_duty);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (pwm_duty === e) n_pass++;
                else $display("FAIL duty_update: got %0d, required %0d", pwm_duty, e);
            end
            prev_duty = pwm_duty;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_target(input logic [31:0] t);
        target_duty  = t;
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
    endtask

    task automatic ramp(input logic [31:0] e);
        exp_q.push_back(e);
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; period_in = 32'd100; step = 32'd10;
        target_duty = '0; target_valid = 1'b0; ovf = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        #12;
        chk("rst_pwm_reset", pwm_reset, 1);
        chk("rst_duty", pwm_duty, 0);
        chk("rst_period", pwm_period, 0);
        chk("rst_enable", pwm_enable, 0);
        chk("rst_ovf_en", ovf_trigger_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault_flag", fault_flag, 0);
        chk("rst_ready", target_ready, 1);
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Soft start 0 -> 35 with step 10.
        send_target(32'd35);
        do_start();
        chk("load_busy", busy, 1);
        chk("load_pwm_reset", pwm_reset, 1);
        chk("load_period", pwm_period, 100);
        chk("load_ready", target_ready, 0);
        tick();
        chk("ramp_pwm_reset", pwm_reset, 0);
        chk("ramp_enable", pwm_enable, 1);
        chk("ramp_ovf_en", ovf_trigger_enable, 1);
        ramp(32'd10);
        ramp(32'd20);
        ramp(32'd30);
        chk("ramp_not_at_target", at_target, 0);
        ramp(32'd35);
        chk("at_target_35", at_target, 1);

        // Slew down 35 -> 5.
        send_target(32'd5);
        chk("hold_to_ramp", at_target, 0);
        ramp(32'd25);
        ramp(32'd15);
        ramp(32'd5);
        chk("at_target_5", at_target, 1);

        // Clamp to period, step 0 acts as 1, upward saturation at target.
        step = 32'd0;
        send_target(32'd500);
        ramp(32'd6);
        ramp(32'd7);
        step = 32'd50;
        ramp(32'd57);
        ramp(32'd100);
        chk("at_target_100", at_target, 1);
        ovf = 1'b1; tick(); ovf = 1'b0; tick();
        chk("hold_no_move", pwm_duty, 100);

        // Downward step past zero must not wrap.
        step = 32'd60;
        send_target(32'd0);
        ramp(32'd40);
        ramp(32'd0);
        chk("at_target_0", at_target, 1);

        // Fault during ramp at duty 20.
        step = 32'd10;
        send_target(32'd35);
        ramp(32'd10);
        ramp(32'd20);
        chk("pre_fault_enable", pwm_enable, 1);
        exp_q.push_back(32'd0);
        fault = 1'b1;
        #1;
        chk("fault_enable_comb", pwm_enable, 0);
        tick();
        fault = 1'b0;
        chk("fault_busy", busy, 0);
        chk("fault_flag_set", fault_flag, 1);
        chk("fault_ready", target_ready, 0);
        do_start();
        tick();
        chk("fault_start_ignored", busy, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_clr", fault_flag, 0);

        // Ramp to 30, then stop from HOLD.
        send_target(32'd30);
        do_start();
        tick();
        ramp(32'd10);
        ramp(32'd20);
        ramp(32'd30);
        chk("at_target_30", at_target, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 1);
`ifdef PWM_RAMP_SOFT_STOP_EN
        ramp(32'd20);
        chk("soft_stop_busy", busy, 1);
        ramp(32'd10);
        ramp(32'd0);
`else
        exp_q.push_back(32'd0);
        tick();
        tick();
`endif
        chk("stop_idle", busy, 0);
        chk("stop_pwm_reset", pwm_reset, 1);
        chk("stop_enable", pwm_enable, 0);

        // Asynchronous reset in the middle of a ramp.
        send_target(32'd50);
        do_start();
        tick();
        ramp(32'd10);
        exp_q.push_back(32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pwm_reset", pwm_reset, 1);
        chk("async_rst_enable", pwm_enable, 0);
        chk("async_rst_period", pwm_period, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ovf_en", ovf_trigger_enable, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
